// File: rtl/rpn_pkg.sv
// Shared types for the RPN evaluator: operator codes, error codes and FSM states.
package rpn_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3
    } op_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_UNDERFLOW = 3'd1,
        ERR_OVERFLOW  = 3'd2,
        ERR_DIV0      = 3'd3,
        ERR_LEFTOVER  = 3'd4
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_DIV,
        S_FIN,
        S_EMIT
    } state_e;

endpackage

// File: rtl/rpn_eval_if.sv
// Character-in / result-out handshake bundle between the parser, the evaluator and the TX side.
interface rpn_eval_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic             is_eol;
    logic             is_op;
    logic [3:0]       op;
    logic             is_space;
    logic [3:0]       digit;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic [2:0]       err_code;

    modport slave (
        input  in_valid, is_eol, is_op, op, is_space, digit, res_ready,
        output in_ready, res_valid, res_data, res_err, err_code
    );

    modport master (
        output in_valid, is_eol, is_op, op, is_space, digit, res_ready,
        input  in_ready, res_valid, res_data, res_err, err_code
    );
endinterface

// File: rtl/rpn_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, quotient only.
// The first step is taken on the start edge so done rises WIDTH cycles after start.
module rpn_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] src_rem, src_quo, src_dvs, step_rem, step_quo;
    logic [WIDTH:0]   trial;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;

    // Remainder stays below the divisor, so the trial value never needs more than WIDTH+1 bits.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor : dvs_q;
        trial   = {src_rem, src_quo[WIDTH-1]};
        if (trial >= {1'b0, src_dvs}) begin
            step_rem = WIDTH'(trial - {1'b0, src_dvs});
            step_quo = {src_quo[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = trial[WIDTH-1:0];
            step_quo = {src_quo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = step_rem;
            quo_d  = step_quo;
            dvs_d  = divisor;
            cnt_d  = CW'(WIDTH - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;
endmodule

// File: rtl/rpn_eval.sv
// Reverse-Polish evaluator: builds decimal operands, runs + - * / on a small stack,
// and emits one result or error word per line.
module rpn_eval
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    rpn_eval_if.slave  bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    state_e                      state_q, state_d;
    logic [DEPTH-1:0][WIDTH-1:0] stk_q, stk_d;
    logic [DW-1:0]               depth_q, depth_d;
    logic [WIDTH-1:0]            acc_q, acc_d;
    logic                        pend_q, pend_d;
    err_e                        err_q, err_d, res_code_q, res_code_d;
    op_e                         op_q, op_d;
    logic [WIDTH-1:0]            res_data_q, res_data_d;

    logic                        push;
    logic [IW-1:0]               idx_a, idx_b, idx_push;
    logic [WIDTH-1:0]            opa, opb;
    logic                        div_start, div_busy, div_done;
    logic [WIDTH-1:0]            div_quo;

    assign idx_b    = IW'(depth_q - DW'(1));
    assign idx_a    = IW'(depth_q - DW'(2));
    assign idx_push = IW'(depth_q);
    assign opa      = stk_q[idx_a];
    assign opb      = stk_q[idx_b];

    rpn_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (opa),
        .divisor  (opb),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_comb begin
        state_d    = state_q;
        stk_d      = stk_q;
        depth_d    = depth_q;
        acc_d      = acc_q;
        pend_d     = pend_q;
        err_d      = err_q;
        op_d       = op_q;
        res_data_d = res_data_q;
        res_code_d = res_code_q;
        push       = 1'b0;
        div_start  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.is_eol) begin
                        push    = pend_q && (err_q == ERR_NONE);
                        acc_d   = '0;
                        pend_d  = 1'b0;
                        state_d = S_FIN;
                    end else if (err_q != ERR_NONE) begin
                        // Line already failed: swallow everything up to EOL.
                        acc_d  = '0;
                        pend_d = 1'b0;
                    end else if (bus.is_op) begin
                        push    = pend_q;
                        acc_d   = '0;
                        pend_d  = 1'b0;
                        op_d    = op_e'(bus.op);
                        state_d = S_EXEC;
                    end else if (bus.is_space) begin
                        push   = pend_q;
                        acc_d  = '0;
                        pend_d = 1'b0;
                    end else if (bus.digit <= 4'd9) begin
                        acc_d  = acc_q * WIDTH'(10) + WIDTH'(bus.digit);
                        pend_d = 1'b1;
                    end
                end
            end

            S_EXEC: begin
                state_d = S_IDLE;
                if (err_q == ERR_NONE) begin
                    if (depth_q < DW'(2)) begin
                        err_d = ERR_UNDERFLOW;
                    end else begin
                        case (op_q)
                            OP_ADD: begin
                                stk_d[idx_a] = opa + opb;
                                depth_d      = depth_q - DW'(1);
                            end
                            OP_SUB: begin
                                stk_d[idx_a] = opa - opb;
                                depth_d      = depth_q - DW'(1);
                            end
                            OP_MUL: begin
                                stk_d[idx_a] = opa * opb;
                                depth_d      = depth_q - DW'(1);
                            end
                            OP_DIV: begin
                                if (opb == '0) begin
                                    err_d = ERR_DIV0;
                                end else begin
                                    div_start = 1'b1;
                                    state_d   = S_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            S_DIV: begin
                if (div_done) begin
                    stk_d[idx_a] = div_quo;
                    depth_d      = depth_q - DW'(1);
                    state_d      = S_IDLE;
                end
            end

            S_FIN: begin
                if (err_q != ERR_NONE) begin
                    res_code_d = err_q;
                    res_data_d = '0;
                    state_d    = S_EMIT;
                end else if (depth_q == DW'(0)) begin
                    state_d = S_IDLE;
                end else if (depth_q == DW'(1)) begin
                    res_data_d = opb;
                    state_d    = S_EMIT;
                end else begin
                    res_code_d = ERR_LEFTOVER;
                    res_data_d = '0;
                    state_d    = S_EMIT;
                end
            end

            S_EMIT: begin
                if (bus.res_ready) begin
                    depth_d    = '0;
                    acc_d      = '0;
                    pend_d     = 1'b0;
                    err_d      = ERR_NONE;
                    res_data_d = '0;
                    res_code_d = ERR_NONE;
                    state_d    = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // A full stack rejects the push and poisons the line.
        if (push) begin
            if (depth_q == DW'(DEPTH)) begin
                err_d = ERR_OVERFLOW;
            end else begin
                stk_d[idx_push] = acc_q;
                depth_d         = depth_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            stk_q      <= '0;
            depth_q    <= '0;
            acc_q      <= '0;
            pend_q     <= 1'b0;
            err_q      <= ERR_NONE;
            op_q       <= OP_ADD;
            res_data_q <= '0;
            res_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            stk_q      <= stk_d;
            depth_q    <= depth_d;
            acc_q      <= acc_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            op_q       <= op_d;
            res_data_q <= res_data_d;
            res_code_q <= res_code_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !div_busy;
    assign bus.res_valid = (state_q == S_EMIT);
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = (res_code_q != ERR_NONE);
    assign bus.err_code  = res_code_q;
endmodule

// File: tb/tb_rpn_eval.sv
// Scoreboarded bench for rpn_eval: drives ASCII lines, checks results, errors and handshake timing.
module tb_rpn_eval;
    localparam int W = 16;
    localparam int D = 8;

    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
        logic [2:0]   code;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rpn_eval_if #(.WIDTH(W)) bus ();

    rpn_eval #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    res_t exp_q[$];
    res_t obs_q[$];
    int total = 0;
    int bad   = 0;

    task automatic send_char(input byte c);
        int n = 0;
        bus.is_eol   = (c == 8'h0a);
        bus.is_op    = (c == "+") || (c == "-") || (c == "*") || (c == "/");
        bus.op       = (c == "-") ? 4'd1 : (c == "*") ? 4'd2 : (c == "/") ? 4'd3 : 4'd0;
        bus.is_space = (c == " ");
        bus.digit    = 4'(c - 8'h30);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL send_char: in_ready still 0 after %0d cycles, want 1", n);
        end else begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic get_result(output bit got);
        int n = 0;
        got = 1'b0;
        while (!bus.res_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (bus.res_valid) begin
            obs_q.push_back('{bus.res_data, bus.res_err, bus.err_code});
            got = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (!bus.in_ready && n < 100) begin
            n++; @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.in_ready, bus.res_valid, bus.res_data, bus.res_err, bus.err_code} !== {1'b1, 1'b0, 16'd0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL reset: rdy=%0b vld=%0b data=%0d err=%0b code=%0d, want 1 0 0 0 0",
                     bus.in_ready, bus.res_valid, bus.res_data, bus.res_err, bus.err_code);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        string       lines[5] = '{"12 34+\n", "2 7-\n", "300 300*\n", "100 7/\n", "7 \n"};
        logic [W-1:0] dat[5]  = '{16'd46, 16'd65531, 16'd24464, 16'd14, 16'd7};
        res_t e, o;
        bit got;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{dat[i], 1'b0, 3'd0});
            send_line(lines[i]);
            get_result(got);
            e = exp_q.pop_front();
            total++;
            if (!got) begin
                bad++;
                $display("FAIL arith[%0d]: no res_valid, want data=%0d", i, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL arith[%0d]: got data=%0d err=%0b code=%0d, want data=%0d err=%0b code=%0d",
                             i, o.data, o.err, o.code, e.data, e.err, e.code);
                end
            end
        end
    endtask

    task automatic test_empty_line();
        int seen = 0;
        send_line("\n");
        for (int i = 0; i < 8; i++) begin
            if (bus.res_valid) seen++;
            @(posedge clk); #1;
        end
        total++;
        if (seen !== 0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL empty_line: res_valid cycles=%0d in_ready=%0b, want 0 and 1", seen, bus.in_ready);
        end
    endtask

    task automatic test_errors();
        string      lines[5] = '{"5 0/\n", "+\n", "1 2 3 4 5 6 7 8 9\n", "1 2\n", "+ 3 4+\n"};
        logic [2:0] codes[5] = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd1};
        res_t e, o;
        bit got;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{16'd0, 1'b1, codes[i]});
            send_line(lines[i]);
            get_result(got);
            e = exp_q.pop_front();
            total++;
            if (!got) begin
                bad++;
                $display("FAIL errors[%0d]: no res_valid, want code=%0d", i, e.code);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL errors[%0d]: got data=%0d err=%0b code=%0d, want data=%0d err=%0b code=%0d",
                             i, o.data, o.err, o.code, e.data, e.err, e.code);
                end
            end
        end
    endtask

    task automatic test_timing();
        string       pre[4]   = '{"8 2", "9 3", "", "4 0"};
        byte         ops[4]   = '{"+", "/", "/", "/"};
        int          busy[4]  = '{1, 17, 1, 1};
        logic [W-1:0] dat[4]  = '{16'd10, 16'd3, 16'd0, 16'd0};
        logic [2:0]  codes[4] = '{3'd0, 3'd0, 3'd1, 3'd3};
        res_t e, o;
        bit got;
        int n;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{dat[i], codes[i] != 3'd0, codes[i]});
            send_line(pre[i]);
            if (i == 0) begin
                total++;
                if (bus.in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL digit_ready: in_ready=%0b after digit, want 1", bus.in_ready);
                end
            end
            send_char(ops[i]);
            count_busy(n);
            total++;
            if (n !== busy[i]) begin
                bad++;
                $display("FAIL busy[%0d]: in_ready low %0d cycles, want %0d", i, n, busy[i]);
            end
            send_char(8'h0a);
            if (i == 0) begin
                // EOL accepted at T: low at T+1, valid at T+2
                total++;
                if (bus.res_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL eol_latency: res_valid=%0b at T+1, want 0", bus.res_valid);
                end
                @(posedge clk); #1;
                total++;
                if (bus.res_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL eol_latency: res_valid=%0b at T+2, want 1", bus.res_valid);
                end
            end
            get_result(got);
            e = exp_q.pop_front();
            total++;
            if (!got) begin
                bad++;
                $display("FAIL timing[%0d]: no res_valid, want data=%0d code=%0d", i, e.data, e.code);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL timing[%0d]: got data=%0d err=%0b code=%0d, want data=%0d err=%0b code=%0d",
                             i, o.data, o.err, o.code, e.data, e.err, e.code);
                end
            end
        end
    endtask

    task automatic test_hold();
        int n = 0;
        int badc = 0;
        res_t e, o;
        bit got;
        bus.res_ready = 1'b0;
        send_line("3 4*\n");
        while (!bus.res_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            if (bus.res_valid !== 1'b1 || bus.res_data !== 16'd12 || bus.in_ready !== 1'b0 || bus.err_code !== 3'd0) badc++;
            @(posedge clk); #1;
        end
        total++;
        if (badc !== 0) begin
            bad++;
            $display("FAIL hold: %0d of 5 stall cycles wrong (vld=%0b data=%0d rdy=%0b), want vld=1 data=12 rdy=0",
                     badc, bus.res_valid, bus.res_data, bus.in_ready);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: vld=%0b rdy=%0b after handshake, want 0 1", bus.res_valid, bus.in_ready);
        end
        exp_q.push_back('{16'd9, 1'b0, 3'd0});
        send_line("9\n");
        get_result(got);
        e = exp_q.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL hold_next: no res_valid, want data=9");
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL hold_next: got data=%0d code=%0d, want data=9 code=0", o.data, o.code);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        res_t e, o;
        bit got;
        send_line("6 3/");
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_div: in_ready=%0b during divide, want 0", bus.in_ready);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.res_valid, bus.res_data, bus.res_err, bus.err_code} !== {1'b1, 1'b0, 16'd0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL mid_div_reset: rdy=%0b vld=%0b data=%0d err=%0b code=%0d, want 1 0 0 0 0",
                     bus.in_ready, bus.res_valid, bus.res_data, bus.res_err, bus.err_code);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back('{16'd2, 1'b0, 3'd0});
        send_line("6 3/\n");
        get_result(got);
        e = exp_q.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL after_reset: no res_valid, want data=2");
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL after_reset: got data=%0d code=%0d, want data=2 code=0", o.data, o.code);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.is_eol    = 1'b0;
        bus.is_op     = 1'b0;
        bus.op        = 4'd0;
        bus.is_space  = 1'b0;
        bus.digit     = 4'd0;
        bus.res_ready = 1'b1;
        test_reset();
        test_arith();
        test_empty_line();
        test_errors();
        test_timing();
        test_hold();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
